// File: rtl/fifo_ser_pkg.sv
// Shared types and helpers for the FIFO word serializer.
package fifo_ser_pkg;

    typedef enum logic [1:0] {IDLE, REQ, CAPTURE, SEND} ser_state_e;

    localparam int BYTE_W = 8;

    function automatic int bytes_per_word(input int data_w);
        return data_w / BYTE_W;
    endfunction

endpackage

// File: rtl/byte_mux_sel.sv
// Combinational selector: returns byte number idx of a word in transmit order.
module byte_mux_sel
    import fifo_ser_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter bit MSB_FIRST = 1'b1,
    parameter int IDX_W     = 2
) (
    input  logic [DATA_W-1:0] word,
    input  logic [IDX_W-1:0]  idx,
    output logic [BYTE_W-1:0] sel_byte
);

    localparam int NBYTES = bytes_per_word(DATA_W);

    always_comb begin
        // NOTE: the default assignment up front keeps this block free of inferred latches.
        sel_byte = '0;
        for (int i = 0; i < NBYTES; i++) begin
            if (idx == IDX_W'(i)) begin
                sel_byte = MSB_FIRST ? word[(NBYTES-1-i)*BYTE_W +: BYTE_W]
                                     : word[i*BYTE_W +: BYTE_W];
            end
        end
    end

endmodule

// File: rtl/fifo_word_serializer.sv
// Pops words from a FIFO and streams them out as bytes on a valid/ready port.
// Optional build macro FIFO_WORD_SERIALIZER_PARITY_EN adds a registered out_parity output.
module fifo_word_serializer
    import fifo_ser_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter bit MSB_FIRST = 1'b1,
    parameter int CNT_W     = 16
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              fifo_empty,
    output logic              fifo_rd_en,
    input  logic [DATA_W-1:0] fifo_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [7:0]        out_data,
    output logic              out_last,
`ifdef FIFO_WORD_SERIALIZER_PARITY_EN
    output logic              out_parity,
`endif
    output logic              busy,
    output logic [CNT_W-1:0]  words_sent
);

    localparam int NBYTES = bytes_per_word(DATA_W);
    localparam int IDX_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

    ser_state_e          state;
    logic [IDX_W-1:0]    byte_idx;
    logic [DATA_W-1:0]   shift_reg;
    logic [DATA_W-1:0]   mux_word;
    logic [IDX_W-1:0]    mux_idx;
    logic [BYTE_W-1:0]   mux_byte;
    logic                handshake;

    assign handshake = out_valid && out_ready;
    assign busy      = (state != IDLE);

    // In CAPTURE the first byte is taken straight from the FIFO read data so that
    // out_data is already registered and valid on the first SEND cycle.
    assign mux_word = (state == CAPTURE) ? fifo_data : shift_reg;
    assign mux_idx  = (state == CAPTURE) ? '0 : byte_idx + IDX_W'(1);

    byte_mux_sel #(
        .DATA_W    (DATA_W),
        .MSB_FIRST (MSB_FIRST),
        .IDX_W     (IDX_W)
    ) u_byte_mux (
        .word     (mux_word),
        .idx      (mux_idx),
        .sel_byte (mux_byte)
    );

    // NOTE: all state is updated with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            state      <= IDLE;
            fifo_rd_en <= 1'b0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_last   <= 1'b0;
            byte_idx   <= '0;
            shift_reg  <= '0;
            words_sent <= '0;
`ifdef FIFO_WORD_SERIALIZER_PARITY_EN
            out_parity <= 1'b0;
`endif
        end else begin
            fifo_rd_en <= 1'b0;
            case (state)
                IDLE: begin
                    if (!fifo_empty) begin
                        state      <= REQ;
                        fifo_rd_en <= 1'b1;
                    end
                end
                REQ: state <= CAPTURE;
                CAPTURE: begin
                    shift_reg <= fifo_data;
                    byte_idx  <= '0;
                    out_valid <= 1'b1;
                    out_data  <= mux_byte;
                    out_last  <= (NBYTES == 1);
`ifdef FIFO_WORD_SERIALIZER_PARITY_EN
                    out_parity <= ^mux_byte;
`endif
                    state     <= SEND;
                end
                SEND: begin
                    if (handshake) begin
                        if (byte_idx == LAST_IDX) begin
                            out_valid  <= 1'b0;
                            out_last   <= 1'b0;
                            words_sent <= words_sent + CNT_W'(1);
                            if (!fifo_empty) begin
                                state      <= REQ;
                                fifo_rd_en <= 1'b1;
                            end else begin
                                state <= IDLE;
                            end
                        end else begin
                            byte_idx <= mux_idx;
                            out_data <= mux_byte;
                            out_last <= (mux_idx == LAST_IDX);
`ifdef FIFO_WORD_SERIALIZER_PARITY_EN
                            out_parity <= ^mux_byte;
`endif
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_word_serializer.sv
// Self-checking bench: two serializers (MSB-first with 4-bit counter, LSB-first) fed by FIFO models.
module tb_fifo_word_serializer;

    typedef struct {
        logic [7:0] d;
        logic       l;
        logic       p;
        int         c;
    } rx_t;

    logic        clock;
    logic        resetn_a, resetn_b;
    logic        empty_a, empty_b, rd_en_a, rd_en_b;
    logic [31:0] data_a, data_b;
    logic        valid_a, valid_b, ready_a, ready_b;
    logic [7:0]  odata_a, odata_b;
    logic        last_a, last_b, busy_a, busy_b;
    logic        par_a, par_b;
    logic [3:0]  ws_a;
    logic [15:0] ws_b;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

`ifndef FIFO_WORD_SERIALIZER_PARITY_EN
    assign par_a = 1'b0;
    assign par_b = 1'b0;
`endif

    fifo_word_serializer #(.DATA_W(32), .MSB_FIRST(1'b1), .CNT_W(4)) dut_a (
        .clock      (clock),
        .resetn     (resetn_a),
        .fifo_empty (empty_a),
        .fifo_rd_en (rd_en_a),
        .fifo_data  (data_a),
        .out_valid  (valid_a),
        .out_ready  (ready_a),
        .out_data   (odata_a),
        .out_last   (last_a),
`ifdef FIFO_WORD_SERIALIZER_PARITY_EN
        .out_parity (par_a),
`endif
        .busy       (busy_a),
        .words_sent (ws_a)
    );

    fifo_word_serializer #(.DATA_W(32), .MSB_FIRST(1'b0), .CNT_W(16)) dut_b (
        .clock      (clock),
        .resetn     (resetn_b),
        .fifo_empty (empty_b),
        .fifo_rd_en (rd_en_b),
        .fifo_data  (data_b),
        .out_valid  (valid_b),
        .out_ready  (ready_b),
        .out_data   (odata_b),
        .out_last   (last_b),
`ifdef FIFO_WORD_SERIALIZER_PARITY_EN
        .out_parity (par_b),
`endif
        .busy       (busy_b),
        .words_sent (ws_b)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    // FIFO models: stimulus writes mem/wr pointer, the pop side owns rd pointer and read data.
    logic [31:0] mem_a [0:63];
    logic [31:0] mem_b [0:63];
    int wr_a = 0, rd_a = 0, pops_a = 0, bad_pops_a = 0;
    int wr_b = 0, rd_b = 0, pops_b = 0, bad_pops_b = 0;

    assign empty_a = (wr_a == rd_a);
    assign empty_b = (wr_b == rd_b);

    always @(posedge clock) begin
        if (rd_en_a) begin
            pops_a <= pops_a + 1;
            if (wr_a == rd_a) bad_pops_a <= bad_pops_a + 1;
            else begin
                data_a <= mem_a[rd_a];
                rd_a   <= rd_a + 1;
            end
        end
    end

    always @(posedge clock) begin
        if (rd_en_b) begin
            pops_b <= pops_b + 1;
            if (wr_b == rd_b) bad_pops_b <= bad_pops_b + 1;
            else begin
                data_b <= mem_b[rd_b];
                rd_b   <= rd_b + 1;
            end
        end
    end

    // Sink monitors: record accepted bytes and count stalls where the offered byte changed or vanished.
    rx_t rx_a[$];
    rx_t rx_b[$];
    int stall_viol_a = 0, stall_viol_b = 0;
    logic stall_a = 1'b0, stall_b = 1'b0;
    logic [7:0] stall_d_a, stall_d_b;
    logic stall_l_a, stall_l_b;

    always @(posedge clock) begin
        if (!resetn_a) stall_a <= 1'b0;
        else begin
            if (stall_a && (!valid_a || odata_a !== stall_d_a || last_a !== stall_l_a))
                stall_viol_a <= stall_viol_a + 1;
            if (valid_a && ready_a) rx_a.push_back('{odata_a, last_a, par_a, cyc});
            stall_a   <= valid_a && !ready_a;
            stall_d_a <= odata_a;
            stall_l_a <= last_a;
        end
    end

    always @(posedge clock) begin
        if (!resetn_b) stall_b <= 1'b0;
        else begin
            if (stall_b && (!valid_b || odata_b !== stall_d_b || last_b !== stall_l_b))
                stall_viol_b <= stall_viol_b + 1;
            if (valid_b && ready_b) rx_b.push_back('{odata_b, last_b, par_b, cyc});
            stall_b   <= valid_b && !ready_b;
            stall_d_b <= odata_b;
            stall_l_b <= last_b;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Reference byte order: plain shift arithmetic on the word.
    function automatic logic [7:0] exp_byte(input logic [31:0] w, input int i, input bit msb);
        int sh;
        sh = msb ? (3 - i) * 8 : i * 8;
        return 8'((w >> sh) & 32'hFF);
    endfunction

    function automatic rx_t get_rx(input int which, input int k);
        rx_t r;
        r.d = 'x; r.l = 1'bx; r.p = 1'bx; r.c = -1;
        if (which == 0) begin
            if (k < rx_a.size()) r = rx_a[k];
        end else if (k < rx_b.size()) r = rx_b[k];
        return r;
    endfunction

    function automatic int rx_count(input int which);
        return (which == 0) ? rx_a.size() : rx_b.size();
    endfunction

    task automatic push(input int which, input logic [31:0] w);
        if (which == 0) begin mem_a[wr_a] = w; wr_a++; end
        else begin mem_b[wr_b] = w; wr_b++; end
    endtask

    // mode 0: ready always high, 1: pattern 1,0,0,1, 2: random (mostly ready)
    task automatic drive(input int which, input int mode, input int target, input int budget);
        int n;
        logic r;
        n = rx_count(which);
        for (int k = 0; k < budget; k++) begin
            @(negedge clock);
            n = rx_count(which);
            if (n >= target) break;
            case (mode)
                0: r = 1'b1;
                1: r = (k % 4 == 0) || (k % 4 == 3);
                default: r = ($urandom_range(0, 3) != 0);
            endcase
            if (which == 0) ready_a = r; else ready_b = r;
        end
        check("drive_bytes_received", 32'(n >= target), 32'd1);
    endtask

    task automatic check_word(input int which, input int base, input logic [31:0] w, input bit msb);
        rx_t r;
        for (int i = 0; i < 4; i++) begin
            r = get_rx(which, base + i);
            check($sformatf("dut%0d_rx%0d_data", which, base + i), 32'(r.d), 32'(exp_byte(w, i, msb)));
            check($sformatf("dut%0d_rx%0d_last", which, base + i), 32'(r.l), 32'(i == 3));
`ifdef FIFO_WORD_SERIALIZER_PARITY_EN
            check($sformatf("dut%0d_rx%0d_parity", which, base + i), 32'(r.p), 32'(^exp_byte(w, i, msb)));
`endif
        end
    endtask

    initial begin : stim
        logic [31:0] words[$];
        logic seen;
        int base;

        resetn_a = 1'b0; resetn_b = 1'b0; ready_a = 1'b0; ready_b = 1'b0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("reset_valid", 32'(valid_a), 0);
        check("reset_data", 32'(odata_a), 0);
        check("reset_last", 32'(last_a), 0);
        check("reset_busy", 32'(busy_a), 0);
        check("reset_words_sent", 32'(ws_a), 0);
        check("reset_rd_en", 32'(rd_en_a), 0);
        resetn_a = 1'b1; resetn_b = 1'b1;

        // Single word, sink always ready: first byte valid three cycles after empty falls.
        ready_a = 1'b1;
        push(0, 32'hA1B2C3D4);
        @(negedge clock); check("latency_c1_valid", 32'(valid_a), 0);
        @(negedge clock); check("latency_c2_valid", 32'(valid_a), 0);
        @(negedge clock); check("latency_c3_valid", 32'(valid_a), 1);
        check("latency_c3_data", 32'(odata_a), 32'hA1);
        drive(0, 0, 4, 50);
        check_word(0, 0, 32'hA1B2C3D4, 1'b1);
        for (int i = 1; i < 4; i++)
            check($sformatf("single_consecutive_%0d", i), 32'(get_rx(0, i).c - get_rx(0, 0).c), 32'(i));
        check("single_pops", 32'(pops_a), 1);
        check("single_words_sent", 32'(ws_a), 1);
        check("single_busy_after", 32'(busy_a), 0);

        // Same word under backpressure.
        push(0, 32'hA1B2C3D4);
        drive(0, 1, 8, 200);
        check_word(0, 4, 32'hA1B2C3D4, 1'b1);
        check("bp_stalls_happened", 32'(get_rx(0, 7).c - get_rx(0, 4).c > 3), 1);
        check("bp_stall_stability", 32'(stall_viol_a), 0);
        check("bp_pops", 32'(pops_a), 2);
        check("bp_words_sent", 32'(ws_a), 2);

        // Empty FIFO for 50 cycles: nothing happens.
        ready_a = 1'b1;
        seen = 1'b0;
        repeat (50) begin
            @(negedge clock);
            if (valid_a || busy_a || rd_en_a) seen = 1'b1;
        end
        check("empty_activity", 32'(seen), 0);
        check("empty_pops", 32'(pops_a), 2);
        check("empty_bad_pops", 32'(bad_pops_a), 0);

        // Reset after two bytes of a word: the word is dropped and not resent.
        push(0, 32'hDEADBEEF);
        drive(0, 0, 10, 50);
        ready_a = 1'b0;
        resetn_a = 1'b0;
        @(negedge clock);
        check("midreset_valid", 32'(valid_a), 0);
        check("midreset_words_sent", 32'(ws_a), 0);
        check("midreset_busy", 32'(busy_a), 0);
        check("midreset_data", 32'(odata_a), 0);
        resetn_a = 1'b1;
        ready_a = 1'b1;
        seen = 1'b0;
        repeat (20) begin
            @(negedge clock);
            if (valid_a || busy_a || rd_en_a) seen = 1'b1;
        end
        check("midreset_quiet", 32'(seen), 0);
        check("midreset_rx_count", 32'(rx_a.size()), 10);
        check("midreset_bytes", 32'(get_rx(0, 8).d) << 8 | 32'(get_rx(0, 9).d), 32'hDEAD);
        check("midreset_pops", 32'(pops_a), 3);

        // 17 random words with random ready: counter wraps from 15 to 0, ends at 1.
        base = 10;
        words.delete();
        for (int i = 0; i < 17; i++) begin
            words.push_back($urandom());
            push(0, words[i]);
        end
        drive(0, 2, base + 68, 3000);
        for (int i = 0; i < 17; i++) check_word(0, base + 4 * i, words[i], 1'b1);
        check("wrap_words_sent", 32'(ws_a), 1);
        check("wrap_pops", 32'(pops_a), 20);
        check("wrap_stability", 32'(stall_viol_a), 0);
        check("wrap_bad_pops", 32'(bad_pops_a), 0);

`ifdef FIFO_WORD_SERIALIZER_PARITY_EN
        push(0, 32'h07030000);
        drive(0, 0, base + 72, 50);
        check("parity_0x07", 32'(get_rx(0, base + 68).p), 1);
        check("parity_0x03", 32'(get_rx(0, base + 69).p), 0);
`endif

        // LSB-first back-to-back words with a two-cycle gap.
        ready_b = 1'b1;
        push(1, 32'h11223344);
        push(1, 32'h55667788);
        drive(1, 0, 8, 100);
        check_word(1, 0, 32'h11223344, 1'b0);
        check_word(1, 4, 32'h55667788, 1'b0);
        check("b2b_gap", 32'(get_rx(1, 4).c - get_rx(1, 3).c), 3);
        check("b2b_in_word", 32'(get_rx(1, 7).c - get_rx(1, 4).c), 3);
        check("b2b_busy_after", 32'(busy_b), 0);
        check("b2b_words_sent", 32'(ws_b), 2);
        check("b2b_pops", 32'(pops_b), 2);

        // Random words on the LSB-first instance.
        words.delete();
        for (int i = 0; i < 10; i++) begin
            words.push_back($urandom());
            push(1, words[i]);
        end
        drive(1, 2, 48, 2000);
        for (int i = 0; i < 10; i++) check_word(1, 8 + 4 * i, words[i], 1'b0);
        check("rand_b_words_sent", 32'(ws_b), 12);
        check("rand_b_stability", 32'(stall_viol_b), 0);
        check("rand_b_bad_pops", 32'(bad_pops_b), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
